// File: rtl/serial_rx_ctrl.sv
// Byte-level frame receiver: N_WORD 16-bit words (high byte first) plus a CRC-16/CCITT-FALSE trailer.
// Optional SERIAL_RX_ERR_CNT_EN adds a saturating error counter output err_cnt.
module serial_rx_ctrl #(
  parameter logic [7:0]  N_WORD  = 8'h01,
  parameter logic [15:0] TIMEOUT = 16'd5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        rx_done,
  input  logic        rx_err,
  output logic [15:0] data_out,
  output logic [7:0]  data_select,
  output logic        data_wr,
  output logic        ready,
  output logic        frame_ok,
  output logic        crc_err,
  output logic        frm_err,
  output logic [2:0]  state
`ifdef SERIAL_RX_ERR_CNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_RX_HI  = 3'b001,
    S_RX_LO  = 3'b010,
    S_CRC_HI = 3'b011,
    S_CRC_LO = 3'b100,
    S_CHECK  = 3'b101
  } state_t;

  state_t      state_q, state_d;
  logic        prev_done_q;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] data_out_q, data_out_d;
  logic [7:0]  data_select_q, data_select_d;
  logic        data_wr_q, data_wr_d;
  logic        ready_q;
  logic        frame_ok_q, frame_ok_d;
  logic        crc_err_q, crc_err_d;
  logic        frm_err_q, frm_err_d;

  logic        ev, good_ev, bad_ev, in_frame, timed_out;
  logic [15:0] crc_upd, crc_first;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // Handshake: a byte is offered when rx_done rises (valid); there is no
  // backpressure, so every rising edge is consumed in the cycle it is seen.
  assign ev        = rx_done && !prev_done_q;
  assign good_ev   = ev && !rx_err;
  assign bad_ev    = ev && rx_err;
  assign crc_upd   = crc_step(crc_q, byte_in);
  assign crc_first = crc_step(16'hFFFF, byte_in);
  assign in_frame  = (state_q == S_RX_HI) || (state_q == S_RX_LO) ||
                     (state_q == S_CRC_HI) || (state_q == S_CRC_LO);
  // Abort edge chosen so the frm_err pulse lands TIMEOUT cycles after the last event cycle.
  assign timed_out = (cnt_q == TIMEOUT - 16'd2);

  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    idx_d         = idx_q;
    crc_d         = crc_q;
    cnt_d         = cnt_q + 16'd1;
    data_out_d    = data_out_q;
    data_select_d = data_select_q;
    data_wr_d     = 1'b0;
    frame_ok_d    = 1'b0;
    crc_err_d     = 1'b0;
    frm_err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d         = 16'd0;
        idx_d         = 8'd0;
        data_select_d = 8'd0;
        if (bad_ev) begin
          frm_err_d = 1'b1;
        end else if (good_ev) begin
          hi_d    = byte_in;
          crc_d   = crc_first;
          state_d = S_RX_LO;
        end
      end
      S_RX_HI: begin
        if (good_ev) begin
          hi_d    = byte_in;
          state_d = S_RX_LO;
        end
      end
      S_RX_LO: begin
        if (good_ev) begin
          data_out_d    = {hi_q, byte_in};
          data_select_d = idx_q;
          data_wr_d     = 1'b1;
          if (idx_q == N_WORD - 8'd1) begin
            state_d = S_CRC_HI;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_RX_HI;
          end
        end
      end
      S_CRC_HI: begin
        if (good_ev) state_d = S_CRC_LO;
      end
      S_CRC_LO: begin
        if (good_ev) begin
          state_d    = S_CHECK;
          frame_ok_d = (crc_upd == 16'h0000);
          crc_err_d  = (crc_upd != 16'h0000);
        end
      end
      S_CHECK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (in_frame) begin
      if (good_ev) begin
        cnt_d = 16'd0;
        crc_d = crc_upd;
      end else if (bad_ev || timed_out) begin
        frm_err_d = 1'b1;
        state_d   = S_IDLE;
      end
    end

    if (state_d == S_IDLE) begin
      crc_d = 16'hFFFF;
      cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    prev_done_q <= rx_done;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      hi_q          <= 8'd0;
      idx_q         <= 8'd0;
      crc_q         <= 16'hFFFF;
      cnt_q         <= 16'd0;
      data_out_q    <= 16'd0;
      data_select_q <= 8'd0;
      data_wr_q     <= 1'b0;
      ready_q       <= 1'b0;
      frame_ok_q    <= 1'b0;
      crc_err_q     <= 1'b0;
      frm_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      idx_q         <= idx_d;
      crc_q         <= crc_d;
      cnt_q         <= cnt_d;
      data_out_q    <= data_out_d;
      data_select_q <= data_select_d;
      data_wr_q     <= data_wr_d;
      ready_q       <= (state_d == S_IDLE);
      frame_ok_q    <= frame_ok_d;
      crc_err_q     <= crc_err_d;
      frm_err_q     <= frm_err_d;
    end
  end

`ifdef SERIAL_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_cnt_q <= 8'd0;
    end else if ((crc_err_d || frm_err_d) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign data_out    = data_out_q;
  assign data_select = data_select_q;
  assign data_wr     = data_wr_q;
  assign ready       = ready_q;
  assign frame_ok    = frame_ok_q;
  assign crc_err     = crc_err_q;
  assign frm_err     = frm_err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Bench for serial_rx_ctrl: one N_WORD=3 and one N_WORD=1 instance, both with TIMEOUT=100.
module tb_serial_rx_ctrl;
  localparam logic [15:0] TO = 16'd100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] byte_in = 8'd0;
  logic       rx_done = 1'b0;
  logic       rx_err = 1'b0;
  logic       sel1 = 1'b0;
  logic       rd1, rd3;

  logic [15:0] d3_data_out, d1_data_out, m_data_out;
  logic [7:0]  d3_data_select, d1_data_select, m_data_select;
  logic        d3_data_wr, d1_data_wr, m_data_wr;
  logic        d3_ready, d1_ready, m_ready;
  logic        d3_frame_ok, d1_frame_ok, m_frame_ok;
  logic        d3_crc_err, d1_crc_err, m_crc_err;
  logic        d3_frm_err, d1_frm_err, m_frm_err;
  logic [2:0]  d3_state, d1_state, m_state;
`ifdef SERIAL_RX_ERR_CNT_EN
  logic [7:0]  d3_err_cnt, d1_err_cnt;
`endif

  assign rd1 = rx_done & sel1;
  assign rd3 = rx_done & ~sel1;

  serial_rx_ctrl #(.N_WORD(8'd3), .TIMEOUT(TO)) dut3 (
    .clk(clk), .reset(reset), .byte_in(byte_in), .rx_done(rd3), .rx_err(rx_err),
    .data_out(d3_data_out), .data_select(d3_data_select), .data_wr(d3_data_wr),
    .ready(d3_ready), .frame_ok(d3_frame_ok), .crc_err(d3_crc_err),
    .frm_err(d3_frm_err), .state(d3_state)
`ifdef SERIAL_RX_ERR_CNT_EN
    , .err_cnt(d3_err_cnt)
`endif
  );

  serial_rx_ctrl #(.N_WORD(8'd1), .TIMEOUT(TO)) dut1 (
    .clk(clk), .reset(reset), .byte_in(byte_in), .rx_done(rd1), .rx_err(rx_err),
    .data_out(d1_data_out), .data_select(d1_data_select), .data_wr(d1_data_wr),
    .ready(d1_ready), .frame_ok(d1_frame_ok), .crc_err(d1_crc_err),
    .frm_err(d1_frm_err), .state(d1_state)
`ifdef SERIAL_RX_ERR_CNT_EN
    , .err_cnt(d1_err_cnt)
`endif
  );

  assign m_data_out    = sel1 ? d1_data_out    : d3_data_out;
  assign m_data_select = sel1 ? d1_data_select : d3_data_select;
  assign m_data_wr     = sel1 ? d1_data_wr     : d3_data_wr;
  assign m_ready       = sel1 ? d1_ready       : d3_ready;
  assign m_frame_ok    = sel1 ? d1_frame_ok    : d3_frame_ok;
  assign m_crc_err     = sel1 ? d1_crc_err     : d3_crc_err;
  assign m_frm_err     = sel1 ? d1_frm_err     : d3_frm_err;
  assign m_state       = sel1 ? d1_state       : d3_state;

  // clock / reset
  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int n_ok = 0, n_crc = 0, n_frm = 0, n_multi = 0;
  int last_wr_cyc = 0, last_res_cyc = 0, last_frm_cyc = 0, ev_cyc = 0;
  logic [23:0] obs_q[$];
  logic [23:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    int np;
    @(posedge clk);
    #1;
    cyc++;
    np = int'(m_data_wr) + int'(m_frame_ok) + int'(m_crc_err) + int'(m_frm_err);
    if (np > 1) n_multi++;
    if (m_data_wr === 1'b1) begin
      obs_q.push_back({m_data_select, m_data_out});
      last_wr_cyc = cyc;
    end
    if (m_frame_ok === 1'b1) begin n_ok++;  last_res_cyc = cyc; end
    if (m_crc_err === 1'b1)  begin n_crc++; last_res_cyc = cyc; end
    if (m_frm_err === 1'b1)  begin n_frm++; last_frm_cyc = cyc; end
  endtask

  // driver: present a byte for one cycle, then hold rx_done low for gap cycles
  task automatic send_byte(input logic [7:0] b, input logic e, input int gap);
    byte_in = b;
    rx_err  = e;
    rx_done = 1'b1;
    ev_cyc  = cyc;
    tick();
    rx_done = 1'b0;
    rx_err  = 1'b0;
    repeat (gap) tick();
  endtask

  function automatic logic [15:0] crc16(input logic [7:0] q[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[i]) begin
      c = c ^ {q[i], 8'h00};
      for (int b = 0; b < 8; b++) c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Reference model + scoreboard for one frame. corrupt_idx flips bit 0 of that byte after the
  // trailer is computed; err_idx marks the byte sent with rx_err (the frame stops there).
  task automatic run_frame(input string tag, input logic [15:0] w[$], input int corrupt_idx,
                           input int err_idx, input int fixed_gap);
    logic [7:0]  bq[$];
    logic [7:0]  dq[$];
    logic [7:0]  txd[$];
    logic [15:0] c;
    logic [23:0] e, o;
    int nw, ok0, crc0, frm0, last_ev;
    bit good;
    nw = w.size();
    foreach (w[i]) begin
      dq.push_back(w[i][15:8]);
      dq.push_back(w[i][7:0]);
    end
    c = crc16(dq);
    bq = dq;
    bq.push_back(c[15:8]);
    bq.push_back(c[7:0]);
    if (corrupt_idx >= 0) bq[corrupt_idx] = bq[corrupt_idx] ^ 8'h01;
    for (int i = 0; i < 2 * nw; i++) txd.push_back(bq[i]);
    good = ({bq[2*nw], bq[2*nw+1]} == crc16(txd));
    exp_q.delete();
    for (int i = 0; i < nw; i++)
      if (err_idx < 0 || 2 * i + 1 < err_idx) exp_q.push_back({8'(i), bq[2*i], bq[2*i+1]});
    obs_q.delete();
    ok0 = n_ok; crc0 = n_crc; frm0 = n_frm; last_ev = 0;
    for (int k = 0; k < bq.size(); k++) begin
      send_byte(bq[k], (k == err_idx), (fixed_gap > 0) ? fixed_gap : int'($urandom_range(4, 1)));
      if (k == 2 * nw - 1 || k == 2 * nw + 1) last_ev = ev_cyc;
      if (k == 2 * nw - 1 && err_idx < 0) chk({tag, " wr_lat"}, last_wr_cyc - last_ev, 1);
      if (k == err_idx) break;
    end
    repeat (3) tick();
    chk({tag, " nwr"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hFFFFFF;
      chk({tag, " wr"}, o, e);
    end
    chk({tag, " frame_ok"}, n_ok - ok0, (err_idx < 0 && good) ? 1 : 0);
    chk({tag, " crc_err"}, n_crc - crc0, (err_idx < 0 && !good) ? 1 : 0);
    chk({tag, " frm_err"}, n_frm - frm0, (err_idx >= 0) ? 1 : 0);
    if (err_idx < 0) chk({tag, " res_lat"}, last_res_cyc - last_ev, 1);
    chk({tag, " state"}, m_state, 3'd0);
    chk({tag, " ready"}, m_ready, 1'b1);
    chk({tag, " sel_idle"}, m_data_select, 8'd0);
    chk({tag, " excl"}, n_multi, 0);
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wq[$];
    logic [7:0]  dq[$];
    logic [15:0] c;
    int f0, ok0, crc0, w, ci, ei;

    // reset with rx_done held high through release
    reset = 1'b0;
    rx_done = 1'b1;
    repeat (2) tick();
    chk("rst state", m_state, 3'd0);
    chk("rst ready", m_ready, 1'b0);
    chk("rst data_out", m_data_out, 16'd0);
    chk("rst select", m_data_select, 8'd0);
    chk("rst pulses", {m_data_wr, m_frame_ok, m_crc_err, m_frm_err}, 4'd0);
    reset = 1'b1;
    tick();
    chk("ready after release", m_ready, 1'b1);
    repeat (2) tick();
    rx_done = 1'b0;
    tick();
    chk("held rx_done state", m_state, 3'd0);
    chk("held rx_done writes", obs_q.size(), 0);
    chk("held rx_done frm", n_frm, 0);

    // N_WORD=1 directed
    sel1 = 1'b1;
    tick();
    wq = {16'h1234};
    run_frame("n1 good", wq, -1, -1, 1);
    wq = {16'h0000};
    wq[0] = 16'($urandom_range(65535, 0));
    run_frame("n1 rand", wq, -1, -1, 0);
    sel1 = 1'b0;
    tick();

    // N_WORD=3 directed
    wq = {16'hA55A, 16'h0001, 16'hFFFF};
    run_frame("n3 good", wq, -1, -1, 1);
    run_frame("n3 corrupt", wq, 2, -1, 1);
    run_frame("n3 rx_err", wq, -1, 1, 1);

    // timeout after a lone hi byte
    f0 = n_frm;
    obs_q.delete();
    send_byte(8'h77, 1'b0, 1);
    w = 0;
    while (n_frm == f0 && w < 200) begin tick(); w++; end
    chk("timeout seen", n_frm - f0, 1);
    chk("timeout latency", last_frm_cyc - ev_cyc, 100);
    chk("timeout state", m_state, 3'd0);
    chk("timeout writes", obs_q.size(), 0);
    wq = {16'h0102, 16'h0304, 16'h0506};
    run_frame("after timeout", wq, -1, -1, 1);
    // events spaced so each lands on the would-be timeout edge
    run_frame("spacing boundary", wq, -1, -1, int'(TO) - 2);

    // randomized frames
    for (int r = 0; r < 10; r++) begin
      wq = {16'h0, 16'h0, 16'h0};
      foreach (wq[i]) wq[i] = 16'($urandom_range(65535, 0));
      ci = ($urandom_range(2, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
      ei = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
      run_frame($sformatf("rand%0d", r), wq, ci, ei, 0);
    end

    // reset asserted while in CRC_LO
    dq = {8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
    c = crc16(dq);
    dq.push_back(c[15:8]);
    foreach (dq[i]) send_byte(dq[i], 1'b0, 1);
    chk("in crc_lo", m_state, 3'd4);
    ok0 = n_ok; crc0 = n_crc; f0 = n_frm;
    reset = 1'b0;
    tick();
    chk("mid rst state", m_state, 3'd0);
    chk("mid rst ready", m_ready, 1'b0);
    chk("mid rst data_out", m_data_out, 16'd0);
    chk("mid rst select", m_data_select, 8'd0);
    chk("mid rst pulses", {m_data_wr, m_frame_ok, m_crc_err, m_frm_err}, 4'd0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("mid rst ready back", m_ready, 1'b1);
    chk("mid rst no pulse", (n_ok - ok0) + (n_crc - crc0) + (n_frm - f0), 0);
    wq = {16'hBEEF, 16'hCAFE, 16'h0F0F};
    run_frame("after mid rst", wq, -1, -1, 2);

`ifdef SERIAL_RX_ERR_CNT_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("err_cnt reset", d3_err_cnt, 8'd0);
    for (int i = 0; i < 10; i++) send_byte(8'h00, 1'b1, 1);
    chk("err_cnt 10", d3_err_cnt, 8'd10);
    for (int i = 0; i < 290; i++) send_byte(8'h00, 1'b1, 1);
    chk("err_cnt sat", d3_err_cnt, 8'hFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_rx_ctrl.md
Name: serial_rx_ctrl

Overview:
Byte-level frame receiver that mirrors the serial TX controller. It consumes bytes from the UART receiver and reassembles N_WORD 16-bit words, high byte first. It then takes a 2-byte CRC-16 trailer (high byte first), writes each word to the downstream register file, and reports frame good, CRC error or framing/timeout error. It sits between the UART RX core and the slave register bank.

Parameters:
N_WORD, 8'h01, number of 16-bit data words per frame (1..255)
TIMEOUT, 16'd5000, max clk cycles between accepted bytes inside a frame before abort (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-low
byte_in  in  8  received byte from UART RX core, valid on rx_done
rx_done  in  1  byte-received flag from UART; a byte is accepted on its rising edge
rx_err  in  1  UART stop-bit/framing error, sampled with the rx_done edge
data_out  out  16  assembled word {hi,lo}
data_select  out  8  index of the word on data_out (0..N_WORD-1)
data_wr  out  1  one-cycle write strobe for data_out/data_select
ready  out  1  high in IDLE (no frame in progress)
frame_ok  out  1  one-cycle pulse: frame complete, CRC correct
crc_err  out  1  one-cycle pulse: frame complete, CRC wrong
frm_err  out  1  one-cycle pulse: frame aborted (timeout or rx_err)
state  out  3  current FSM state, for debug

Behaviour:
- Edge detect: prev_done <= rx_done every cycle, including during reset. An event is rx_done && !prev_done, so a level held high through reset release is not an event.
- Reset (reset==0 at posedge): state=IDLE, data_out=0, data_select=0, data_wr=0, ready=0, frame_ok=crc_err=frm_err=0, crc=16'hFFFF, timeout counter=0. ready goes to 1 on the first cycle after reset is released. Reset mid-frame discards the frame with no pulses.
- CRC: CRC-16/CCITT-FALSE (poly 0x1021, init 0xFFFF, MSB first, no reflection, no xorout). It is updated in one cycle per accepted byte, covering all data bytes and both CRC bytes. The check passes when the final residue is 16'h0000.
- States (3-bit encoding):
  - IDLE=000: ready=1, crc=FFFF, data_select=0. On event -> latch hi byte, update crc, -> RX_LO.
  - RX_HI=001: on event -> latch hi, update crc -> RX_LO.
  - RX_LO=010: on event -> update crc. Next cycle data_out={hi,byte_in}, data_wr=1, data_select=current index. If index==N_WORD-1 -> CRC_HI; else index+1 -> RX_HI.
  - CRC_HI=011: on event -> update crc -> CRC_LO.
  - CRC_LO=100: on event -> update crc -> CHECK.
  - CHECK=101: exactly one cycle. If crc==0, frame_ok=1; otherwise crc_err=1. -> IDLE.
  - 110/111: illegal, -> IDLE next cycle, no pulses.
- data_wr, frame_ok, crc_err and frm_err are one-cycle pulses and are mutually exclusive per cycle. The data_wr latency is 1 cycle after the lo-byte event.
- Timeout: the counter clears on every event and in IDLE, and increments in every other state. When it reaches TIMEOUT: frm_err=1, -> IDLE, crc re-init. Words already written stay written; the consumer discards them unless frame_ok follows.
- rx_err high at an event in any state: byte discarded, frm_err=1, -> IDLE. An rx_err event in IDLE also pulses frm_err.
- An event arriving in CHECK is ignored. UART byte spacing makes this unreachable in the system.
- Timeout and event in the same cycle: the event wins and the counter clears.

Optional Feature:
SERIAL_RX_ERR_CNT_EN
- Defined: adds output err_cnt[7:0]. It increments on every crc_err or frm_err pulse, saturates at 8'hFF, clears on reset only.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- N_WORD=1: send 0x12,0x34 plus the correct CRC bytes from a golden model -> data_wr with data_out=16'h1234 and data_select=0 one cycle after the 2nd byte; frame_ok pulse one cycle after the CRC low byte; ready back to 1.
- N_WORD=3: words 0xA55A, 0x0001, 0xFFFF with correct CRC -> three data_wr pulses, data_select 0,1,2, then frame_ok. Repeat with byte 3 flipped to 0x01 -> three writes, then crc_err=1, frame_ok=0.
- TIMEOUT=100: send one hi byte then nothing -> frm_err exactly 100 cycles after the event, state=IDLE. The next full frame is received correctly (crc re-initialised).
- rx_err=1 on the 2nd byte -> no data_wr, frm_err pulse, IDLE. Hold rx_done=1 across reset release -> no byte accepted.
- Assert reset low in CRC_LO -> all outputs at reset values, no pulse. With SERIAL_RX_ERR_CNT_EN, 300 bad frames -> err_cnt=8'hFF.
